// File: rtl/frame_fifo_pkg.sv
// Shared widths, helpers and types for the frame FIFO.
// Imported by the pointer/flag logic in frame_fifo.
package frame_fifo_pkg;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int unsigned DEF_SAMPLE_SIZE  = 24;
    localparam int unsigned DEF_NUM_CHANNELS = 2;
    localparam int unsigned DEF_FRAME_LEN    = 64;
    localparam int unsigned DEF_FIFO_DEPTH   = 16;

    localparam int unsigned DEF_AW = clog2(DEF_FRAME_LEN);
    localparam int unsigned DEF_PW = clog2(DEF_FIFO_DEPTH);
    localparam int unsigned DEF_LW = clog2(DEF_FIFO_DEPTH + 1);
    localparam int unsigned DEF_DW = DEF_NUM_CHANNELS * DEF_SAMPLE_SIZE;

    // Net effect of one cycle's accepted commit/release on occupancy.
    typedef enum logic [1:0] {
        LVL_HOLD = 2'd0,
        LVL_INC  = 2'd1,
        LVL_DEC  = 2'd2
    } lvl_op_e;

    // A simultaneous commit and release leaves occupancy unchanged.
    function automatic lvl_op_e lvl_op(
        input logic push,
        input logic pop
    );
        lvl_op_e op;
        op = LVL_HOLD;
        unique case (1'b1)
            (push && !pop): op = LVL_INC;
            (pop && !push): op = LVL_DEC;
            default:        op = LVL_HOLD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/sample_ram_dp.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Same-address write and read in one cycle returns the old word.
module sample_ram_dp #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage array; never reset so frame contents survive rst.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read register samples the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_fifo.sv
// Frame FIFO: producer fills the head frame randomly, consumer reads the
// tail frame randomly; whole frames are committed and released.
module frame_fifo
    import frame_fifo_pkg::*;
#(
    parameter  int unsigned SAMPLE_SIZE  = DEF_SAMPLE_SIZE,
    parameter  int unsigned NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter  int unsigned FRAME_LEN    = DEF_FRAME_LEN,
    parameter  int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
    localparam int unsigned AW = clog2(FRAME_LEN),
    localparam int unsigned PW = clog2(FIFO_DEPTH),
    localparam int unsigned LW = clog2(FIFO_DEPTH + 1),
    localparam int unsigned DW = NUM_CHANNELS * SAMPLE_SIZE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_commit,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    input  logic          rd_release,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output logic          overrun,
    output logic          underrun,
    input  logic          clr_err
);

    localparam logic [PW-1:0] LAST_SLOT = PW'(FIFO_DEPTH - 1);
    localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          ovr_q, ovr_d;
    logic          und_q, und_d;

    logic          rel_ok;
    logic          room;
    logic          cmt_ok;
    logic          wr_ok;
    logic          ovr_evt;
    logic          und_evt;
    lvl_op_e       op;

    // Accept/reject decisions; a release frees a slot for a same-cycle
    // commit or write even when the FIFO is full.
    always_comb begin
        rel_ok  = rd_release && !empty_q;
        room    = !full_q || rel_ok;
        cmt_ok  = wr_commit && room;
        wr_ok   = wr_en && room;
        ovr_evt = (wr_en || wr_commit) && !room;
        und_evt = rd_release && empty_q;
        op      = lvl_op(cmt_ok, rel_ok);
    end

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        ovr_d   = ovr_q;
        und_d   = und_q;

        if (cmt_ok) begin
            head_d = (head_q == LAST_SLOT) ? '0 : head_q + PW'(1);
        end
        if (rel_ok) begin
            tail_d = (tail_q == LAST_SLOT) ? '0 : tail_q + PW'(1);
        end

        unique case (op)
            LVL_INC: level_d = level_q + LW'(1);
            LVL_DEC: level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        full_d  = (level_d == FULL_LVL);
        empty_d = (level_d == '0);

        if (clr_err) begin
            ovr_d = 1'b0;
            und_d = 1'b0;
        end else begin
            ovr_d = ovr_q || ovr_evt;
            und_d = und_q || und_evt;
        end
    end

    // State registers; reset overrides any in-flight commit or release.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovr_q   <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovr_q   <= ovr_d;
            und_q   <= und_d;
        end
    end

    sample_ram_dp #(
        .ADDR_W (PW + AW),
        .DATA_W (DW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_ok),
        .waddr_i ({head_q, wr_addr}),
        .wdata_i (wr_data),
        .raddr_i ({tail_q, rd_addr}),
        .rdata_o (rd_data)
    );

    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign overrun  = ovr_q;
    assign underrun = und_q;

endmodule

// File: tb/tb_frame_fifo.sv
// Directed bench for frame_fifo: default-size instance plus a
// FIFO_DEPTH=5 instance for pointer wrap.
module tb_frame_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // default instance (AW=6, PW=4, LW=5, DW=48)
    logic        wr_en = 0;
    logic [5:0]  wr_addr = '0;
    logic [47:0] wr_data = '0;
    logic        wr_commit = 0;
    logic [5:0]  rd_addr = '0;
    logic [47:0] rd_data;
    logic        rd_release = 0;
    logic        full, empty;
    logic [4:0]  level;
    logic        overrun, underrun;
    logic        clr_err = 0;

    frame_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_commit  (wr_commit),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_release (rd_release),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .overrun    (overrun),
        .underrun   (underrun),
        .clr_err    (clr_err)
    );

    // wrap instance (FRAME_LEN=4, FIFO_DEPTH=5: AW=2, PW=3, LW=3, DW=16)
    logic        w5_wr_en = 0;
    logic [1:0]  w5_wr_addr = '0;
    logic [15:0] w5_wr_data = '0;
    logic        w5_wr_commit = 0;
    logic [1:0]  w5_rd_addr = '0;
    logic [15:0] w5_rd_data;
    logic        w5_rd_release = 0;
    logic        w5_full, w5_empty;
    logic [2:0]  w5_level;
    logic        w5_overrun, w5_underrun;
    logic        w5_clr_err = 0;

    frame_fifo #(
        .SAMPLE_SIZE  (8),
        .NUM_CHANNELS (2),
        .FRAME_LEN    (4),
        .FIFO_DEPTH   (5)
    ) dut5 (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (w5_wr_en),
        .wr_addr    (w5_wr_addr),
        .wr_data    (w5_wr_data),
        .wr_commit  (w5_wr_commit),
        .rd_addr    (w5_rd_addr),
        .rd_data    (w5_rd_data),
        .rd_release (w5_rd_release),
        .full       (w5_full),
        .empty      (w5_empty),
        .level      (w5_level),
        .overrun    (w5_overrun),
        .underrun   (w5_underrun),
        .clr_err    (w5_clr_err)
    );

    int tests = 0;
    int fails = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs,
                       input logic [47:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset
        rst = 1;
        tick();
        tick();
        rst = 0;
        chk("rst_level", 48'(level), 48'd0);
        chk("rst_empty", 48'(empty), 48'd1);
        chk("rst_full", 48'(full), 48'd0);
        chk("rst_rdata", rd_data, 48'd0);
        chk("rst_ovr", 48'(overrun), 48'd0);
        chk("rst_und", 48'(underrun), 48'd0);

        // underrun on release while empty, then clear
        rd_release = 1;
        tick();
        rd_release = 0;
        chk("und_set", 48'(underrun), 48'd1);
        chk("und_level", 48'(level), 48'd0);
        chk("und_tail", 48'(dut.tail_q), 48'd0);
        clr_err = 1;
        tick();
        chk("und_clr", 48'(underrun), 48'd0);
        // clear wins over a same-cycle error
        rd_release = 1;
        tick();
        rd_release = 0;
        clr_err = 0;
        chk("clr_prio", 48'(underrun), 48'd0);

        // write frame 0 with addr*3, commit, read back
        for (int a = 0; a < 64; a++) begin
            wr_en = 1;
            wr_addr = 6'(a);
            wr_data = 48'(a * 3);
            tick();
        end
        wr_en = 0;
        wr_commit = 1;
        tick();
        wr_commit = 0;
        chk("w1_level", 48'(level), 48'd1);
        chk("w1_empty", 48'(empty), 48'd0);
        for (int a = 0; a < 64; a++) begin
            rd_addr = 6'(a);
            tick();
            chk("w1_rd", rd_data, 48'(a * 3));
        end
        rd_release = 1;
        tick();
        rd_release = 0;
        chk("w1_rel_level", 48'(level), 48'd0);
        chk("w1_rel_empty", 48'(empty), 48'd1);

        // fill to capacity: head=tail=1, slot (1+k)%16 addr0 = 100+k
        for (int k = 0; k < 16; k++) begin
            wr_en = 1;
            wr_addr = 6'd0;
            wr_data = 48'(100 + k);
            wr_commit = 1;
            tick();
        end
        chk("fill_level", 48'(level), 48'd16);
        chk("fill_full", 48'(full), 48'd1);
        chk("fill_head", 48'(dut.head_q), 48'd1);
        chk("fill_ovr0", 48'(overrun), 48'd0);
        // 17th commit (and write) rejected
        wr_data = 48'd999;
        rd_addr = 6'd0;
        tick();
        wr_en = 0;
        wr_commit = 0;
        chk("ovr_set", 48'(overrun), 48'd1);
        chk("ovr_level", 48'(level), 48'd16);
        chk("ovr_head", 48'(dut.head_q), 48'd1);
        clr_err = 1;
        tick();
        clr_err = 0;
        chk("ovr_clr", 48'(overrun), 48'd0);
        chk("ovr_nowrite", rd_data, 48'd100);

        // commit + release while full
        wr_en = 1;
        wr_addr = 6'd0;
        wr_data = 48'd200;
        wr_commit = 1;
        rd_release = 1;
        tick();
        wr_en = 0;
        wr_commit = 0;
        rd_release = 0;
        chk("both_level", 48'(level), 48'd16);
        chk("both_full", 48'(full), 48'd1);
        chk("both_head", 48'(dut.head_q), 48'd2);
        chk("both_tail", 48'(dut.tail_q), 48'd2);
        chk("both_ovr", 48'(overrun), 48'd0);
        tick();
        chk("both_rd", rd_data, 48'd101);
        rd_release = 1;
        tick();
        rd_release = 0;
        chk("rel_level", 48'(level), 48'd15);
        chk("rel_full", 48'(full), 48'd0);

        // reset mid-operation with level 7
        rst = 1;
        tick();
        rst = 0;
        rd_addr = 6'd5;
        for (int k = 0; k < 7; k++) begin
            wr_commit = 1;
            tick();
        end
        chk("mid_level7", 48'(level), 48'd7);
        chk("mid_rd_pre", rd_data, 48'd15);
        rst = 1;
        wr_commit = 1;
        rd_release = 1;
        tick();
        chk("mid_level", 48'(level), 48'd0);
        chk("mid_empty", 48'(empty), 48'd1);
        chk("mid_full", 48'(full), 48'd0);
        chk("mid_rdata", rd_data, 48'd0);
        chk("mid_ovr", 48'(overrun), 48'd0);
        chk("mid_und", 48'(underrun), 48'd0);
        chk("mid_head", 48'(dut.head_q), 48'd0);
        chk("mid_tail", 48'(dut.tail_q), 48'd0);
        rst = 0;
        wr_commit = 0;
        rd_release = 0;
        tick();
        chk("mid_ram_kept", rd_data, 48'd15);

        // wrap: 12 commit/release pairs on depth 5
        for (int k = 0; k < 12; k++) begin
            for (int a = 0; a < 4; a++) begin
                w5_wr_en = 1;
                w5_wr_addr = 2'(a);
                w5_wr_data = 16'(k * 16 + a);
                tick();
            end
            w5_wr_en = 0;
            w5_wr_commit = 1;
            tick();
            w5_wr_commit = 0;
            chk("w5_level1", 48'(w5_level), 48'd1);
            for (int a = 0; a < 4; a++) begin
                w5_rd_addr = 2'(a);
                tick();
                chk("w5_rd", 48'(w5_rd_data), 48'(k * 16 + a));
            end
            w5_rd_release = 1;
            tick();
            w5_rd_release = 0;
            chk("w5_level0", 48'(w5_level), 48'd0);
        end
        chk("w5_head", 48'(dut5.head_q), 48'd2);
        chk("w5_tail", 48'(dut5.tail_q), 48'd2);
        chk("w5_ovr", 48'(w5_overrun), 48'd0);
        chk("w5_und", 48'(w5_underrun), 48'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_fifo.md
FRAME_FIFO -- requirements
Module: frame_fifo

Interface
REQ-001 SHALL have parameter SAMPLE_SIZE, default 24, bits per channel sample.
REQ-002 SHALL have parameter NUM_CHANNELS, default 2, samples stored side by side per address.
REQ-003 SHALL have parameter FRAME_LEN, default 64, samples per frame; FRAME_LEN >= 2.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, frames held; any value >= 2, not only powers of two.
REQ-005 SHALL have derived widths AW = clog2(FRAME_LEN), PW = clog2(FIFO_DEPTH), LW = clog2(FIFO_DEPTH+1), DW = NUM_CHANNELS*SAMPLE_SIZE.
REQ-006 SHALL have port clk, input, 1, clock; all logic rising-edge.
REQ-007 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have port wr_en, input, 1, write one address of the head frame.
REQ-009 SHALL have port wr_addr, input, AW, sample index within the head frame.
REQ-010 SHALL have port wr_data, input, DW, channel 0 in the LSBs.
REQ-011 SHALL have port wr_commit, input, 1, head frame complete, advance head.
REQ-012 SHALL have port rd_addr, input, AW, sample index within the tail frame.
REQ-013 SHALL have port rd_data, output, DW, registered read data.
REQ-014 SHALL have port rd_release, input, 1, tail frame consumed, advance tail.
REQ-015 SHALL have ports full and empty, output, 1 each, frame-occupancy flags.
REQ-016 SHALL have port level, output, LW, committed frames held.
REQ-017 SHALL have ports overrun and underrun, output, 1 each, sticky error flags.
REQ-018 SHALL have port clr_err, input, 1, clears both error flags.

Function
REQ-019 SHALL write wr_data to {head, wr_addr} on wr_en when full = 0, or when full = 1 and a release is accepted in the same cycle.
REQ-020 SHALL drop wr_en while full with no accepted release, and set overrun.
REQ-021 SHALL present the data at {tail, rd_addr} on rd_data one cycle after rd_addr, every cycle, with no read enable; rd_data is undefined when empty = 1.
REQ-022 SHALL treat a write and a read to the same RAM address in the same cycle as returning old data.
REQ-023 SHALL accept rd_release only when empty = 0; otherwise tail is unchanged and underrun is set.
REQ-024 SHALL accept wr_commit when full = 0, or when full = 1 and rd_release is accepted in the same cycle; otherwise head is unchanged and overrun is set.
REQ-025 SHALL wrap head and tail from FIFO_DEPTH-1 to 0, and increment them by 1 otherwise.
REQ-026 SHALL update level as +1 on commit only, -1 on release only, and unchanged when both or neither are accepted.
REQ-027 SHALL derive full = (level == FIFO_DEPTH) and empty = (level == 0), both registered with level.
REQ-028 SHALL have clr_err take priority over same-cycle error setting.

Reset
REQ-029 SHALL on rst clear head, tail, level, overrun, underrun and rd_data to 0, set empty = 1 and full = 0, regardless of in-flight commit or release.
REQ-030 SHALL NOT clear RAM contents on rst.

Structure
REQ-031 SHALL place derived widths (AW, PW, LW, DW) and a clog2 function in a shared package/header used by the producer and consumer blocks.
REQ-032 SHALL use one sub-module, sample_ram_dp: a simple dual-port RAM with one write port and one registered read port, depth 2^(PW+AW), width DW, addressed {slot, addr}.
REQ-033 SHALL keep all pointer, level and flag logic in frame_fifo, with no per-slot RAM instances.

Verification
REQ-034 SHALL cover write-then-read: fill frame 0 with addr 0..63 = addr*3, commit, read 0..63 -> rd_data = addr*3 one cycle later, level = 1 then 0 after release.
REQ-035 SHALL cover fill to capacity: 16 commits with no release -> full = 1, level = 16; a 17th commit -> overrun = 1, head unchanged, level = 16.
REQ-036 SHALL cover underrun: rd_release after reset -> underrun = 1, level = 0; clr_err -> underrun = 0.
REQ-037 SHALL cover simultaneous commit and release while full -> both accepted, level stays 16, head and tail both advance.
REQ-038 SHALL cover wrap with FIFO_DEPTH = 5: 12 commit/release pairs -> head = tail = 2, data integrity checked per frame.
REQ-039 SHALL cover reset mid-operation: rst with level = 7 during a commit -> next cycle level = 0, empty = 1, rd_data = 0, flags = 0.
